gg_line_scaler: RTL and testbench

GG_LINE_SCALER -- requirements
Module: gg_line_scaler

---
 rtl/gg_line_scaler.sv | 182 ++++++++++++++++++
 tb/tb_gg_line_scaler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gg_line_scaler.sv
// gg_line_scaler: double-buffered line store that upscales a SRC_W x SRC_H
// source image by an integer factor of 3 into a VGA raster.
// The writer fills one line bank while the VGA side shows the other. Each
// bank line is shown for 3 rows with every pixel repeated over 3 columns.
// Optional feature macro: SCALER_SCANLINE_EN. When defined, the third row of
// each triplet is shown at half intensity.
module gg_line_scaler #(
    parameter int          SRC_W  = 160,
    parameter int          SRC_H  = 144,
    parameter int          X_OFF  = 80,
    parameter int          Y_OFF  = 24,
    parameter logic [11:0] BORDER = 12'h000
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [11:0] in_data,
    input  logic        in_sof,
    output logic        in_ready,
    input  logic        pix_ce,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        active,
    output logic [11:0] rgb,
    output logic        underflow
);

    // Address widths. IW has one spare code so the column index may step
    // one past the last source pixel without wrapping inside the window.
    localparam int AW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int IW = $clog2(SRC_W + 1);
    localparam int RW = (SRC_H > 1) ? $clog2(SRC_H) : 1;

    // Window edges in VGA coordinates (inclusive).
    localparam logic [9:0] X_FIRST = 10'(X_OFF);
    localparam logic [9:0] X_LAST  = 10'(X_OFF + 3 * SRC_W - 1);
    localparam logic [9:0] Y_FIRST = 10'(Y_OFF);
    localparam logic [9:0] Y_LAST  = 10'(Y_OFF + 3 * SRC_H - 1);

    // Line banks; contents are deliberately not reset.
    logic [11:0]   line_mem [2][SRC_W];

    // Write-side state.
    logic [1:0]    full;
    logic [1:0]    full_nx;
    logic          wr_bank;
    logic          wr_bank_nx;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] src_row;
    logic [RW-1:0] row_base;
    logic          accept;
    logic          line_done;

    // Read-side state.
    logic          rd_bank;
    logic [1:0]    hsub;
    logic [1:0]    cur_sub;
    logic [IW-1:0] hidx;
    logic [IW-1:0] cur_idx;
    logic [1:0]    vrep;
    logic [1:0]    cur_rep;
    logic [AW-1:0] rd_addr;
    logic          h_win;
    logic          v_win;
    logic          row_end;
    logic          free_evt;
    logic [11:0]   win_pix;

    // Source handshake: an in_sof pixel always lands at address 0 and
    // restarts the source row count.
    always_comb begin
        accept    = in_valid & in_ready;
        wr_addr   = in_sof ? '0 : wr_ptr;
        line_done = accept && (wr_addr == AW'(SRC_W - 1));
        row_base  = in_sof ? '0 : src_row;
    end

    // Raster decode. The sub/index/repeat registers hold the values for the
    // next column/row; the first window column and row force them to zero so
    // no division by 3 is ever needed.
    always_comb begin
        h_win    = (hcount >= X_FIRST) && (hcount <= X_LAST);
        v_win    = (vcount >= Y_FIRST) && (vcount <= Y_LAST);
        cur_sub  = (hcount == X_FIRST) ? 2'd0 : hsub;
        cur_idx  = (hcount == X_FIRST) ? '0 : hidx;
        cur_rep  = (vcount == Y_FIRST) ? 2'd0 : vrep;
        row_end  = pix_ce && v_win && (hcount == X_LAST);
        free_evt = row_end && (cur_rep == 2'd2);
        rd_addr  = (cur_idx < IW'(SRC_W)) ? cur_idx[AW-1:0] : '0;
        win_pix  = line_mem[rd_bank][rd_addr];
`ifdef SCALER_SCANLINE_EN
        if (cur_rep == 2'd2) begin
            win_pix = {1'b0, win_pix[11:9], 1'b0, win_pix[7:5], 1'b0, win_pix[3:1]};
        end
`endif
    end

    // Bank flags: a free and a completion hitting the same bank in one cycle
    // leave it full, so the completion is applied last.
    always_comb begin
        full_nx = full;
        if (free_evt) begin
            full_nx[rd_bank] = 1'b0;
        end
        if (line_done) begin
            full_nx[wr_bank] = 1'b1;
        end
        wr_bank_nx = wr_bank ^ line_done;
    end

    // Write-side registers; in_ready reflects the emptiness of the bank the
    // writer will target next.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            wr_ptr   <= '0;
            src_row  <= '0;
            in_ready <= 1'b0;
        end else begin
            full     <= full_nx;
            wr_bank  <= wr_bank_nx;
            in_ready <= ~full_nx[wr_bank_nx];
            if (accept) begin
                wr_ptr <= line_done ? '0 : wr_addr + AW'(1);
                if (line_done) begin
                    src_row <= (row_base == RW'(SRC_H - 1)) ? '0 : row_base + RW'(1);
                end else begin
                    src_row <= row_base;
                end
            end
        end
    end

    // Bank storage write port.
    always_ff @(posedge clk_50) begin
        if (accept) begin
            line_mem[wr_bank][wr_addr] <= in_data;
        end
    end

    // Pixel-rate pipeline: counters, read-bank hand-over and output pixel.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rgb       <= 12'h000;
            underflow <= 1'b0;
            hsub      <= 2'd0;
            hidx      <= '0;
            vrep      <= 2'd0;
            rd_bank   <= 1'b0;
        end else if (pix_ce) begin
            if (cur_sub == 2'd2) begin
                hsub <= 2'd0;
                hidx <= cur_idx + IW'(1);
            end else begin
                hsub <= cur_sub + 2'd1;
                hidx <= cur_idx;
            end
            if (row_end) begin
                vrep <= (cur_rep == 2'd2) ? 2'd0 : cur_rep + 2'd1;
            end
            // End of a triplet: move on if the next line is ready, otherwise
            // keep showing the old one and flag the miss.
            if (free_evt) begin
                if (full[~rd_bank]) begin
                    rd_bank <= ~rd_bank;
                end else begin
                    underflow <= 1'b1;
                end
            end
            if (!active) begin
                rgb <= 12'h000;
            end else if (h_win && v_win) begin
                rgb <= win_pix;
            end else begin
                rgb <= BORDER;
            end
        end
    end

endmodule

// File: tb/tb_gg_line_scaler.sv
// Self-checking bench for gg_line_scaler: a bank-level behavioural model
// (pixel index = (h-X_OFF)/3, repeat = (v-Y_OFF)%3) checked every cycle,
// plus literal expectations on captured rows.
module tb_gg_line_scaler;
  localparam int SRC_W = 160;
  localparam int SRC_H = 144;
  localparam int X_OFF = 80;
  localparam int Y_OFF = 24;
  localparam logic [11:0] BORDER = 12'h123;
  localparam int X_END = X_OFF + 3 * SRC_W;
  localparam int Y_END = Y_OFF + 3 * SRC_H;
  localparam int HTOT = 660;

  logic clk_50 = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic [11:0] in_data = 12'h000;
  logic in_sof = 1'b0;
  logic in_ready;
  logic pix_ce = 1'b0;
  logic [9:0] hcount = 10'd0;
  logic [9:0] vcount = 10'd0;
  logic active = 1'b0;
  logic [11:0] rgb;
  logic underflow;

  gg_line_scaler #(.SRC_W(SRC_W), .SRC_H(SRC_H), .X_OFF(X_OFF), .Y_OFF(Y_OFF), .BORDER(BORDER)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .in_ready(in_ready), .pix_ce(pix_ce), .hcount(hcount), .vcount(vcount), .active(active),
    .rgb(rgb), .underflow(underflow));

  always #10 clk_50 = ~clk_50;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state.
  logic [11:0] mb [2][SRC_W];
  bit          mk [2][SRC_W];
  bit          mfull [2];
  int          mwb, mrb, mwp, m_acc;
  bit          m_ready, m_uf, m_known, last_acc;
  logic [11:0] m_rgb;
  int          wmode = 0;
  logic [11:0] cap [HTOT];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mfull[0] = 0; mfull[1] = 0;
    mwb = 0; mrb = 0; mwp = 0;
    m_ready = 0; m_uf = 0; m_rgb = 12'h000; m_known = 1; last_acc = 0;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    bit acc, done, free, other;
    int h, v, rep, addr, idx;
    done = 0; free = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      acc = in_valid && m_ready;
      if (pix_ce) begin
        h = int'(hcount);
        v = int'(vcount);
        rep = (v >= Y_OFF) ? (v - Y_OFF) % 3 : 0;
        if (!active) begin
          m_rgb = 12'h000; m_known = 1;
        end else if (h >= X_OFF && h < X_END && v >= Y_OFF && v < Y_END) begin
          idx = (h - X_OFF) / 3;
          m_rgb = mb[mrb][idx];
          m_known = mk[mrb][idx];
`ifdef SCALER_SCANLINE_EN
          if (rep == 2) m_rgb = (m_rgb >> 1) & 12'h777;
`endif
        end else begin
          m_rgb = BORDER; m_known = 1;
        end
        free = (v >= Y_OFF) && (v < Y_END) && (h == X_END - 1) && (rep == 2);
      end
      if (acc) begin
        addr = in_sof ? 0 : mwp;
        mb[mwb][addr] = in_data;
        mk[mwb][addr] = 1;
        m_acc++;
        if (addr == SRC_W - 1) begin done = 1; mwp = 0; end
        else mwp = addr + 1;
      end
      if (free) begin
        other = mfull[1 - mrb];
        mfull[mrb] = 0;
        if (other) mrb = 1 - mrb;
        else m_uf = 1;
      end
      if (done) begin
        mfull[mwb] = 1;
        mwb = 1 - mwb;
      end
      m_ready = !mfull[mwb];
      last_acc = acc;
    end
  endtask

  // One clock: model, edge, then compare all outputs.
  task automatic step();
    model_edge();
    @(posedge clk_50);
    #1;
    chk("in_ready", 12'(in_ready), 12'(m_ready));
    chk("underflow", 12'(underflow), 12'(m_uf));
    if (m_known) chk("rgb", rgb, m_rgb);
  endtask

  task automatic drive_write();
    if (wmode == 1) begin
      in_valid = 1'($urandom % 2);
      in_data = 12'($urandom);
      in_sof = ($urandom % 150) == 0;
    end else begin
      in_valid = 0;
      in_sof = 0;
    end
  endtask

  task automatic sweep_row(input int v, input bit rnd);
    int gaps;
    for (int h = 0; h < HTOT; h++) begin
      hcount = 10'(h); vcount = 10'(v); active = (h < 640); pix_ce = 1;
      drive_write();
      step();
      cap[h] = rgb;
      pix_ce = 0;
      gaps = rnd ? int'($urandom_range(0, 2)) : 1;
      for (int g = 0; g < gaps; g++) begin
        drive_write();
        step();
      end
    end
    in_valid = 0; in_sof = 0; active = 0;
  endtask

  task automatic push(input int n, input logic [11:0] d, input bit sof_first);
    bit got;
    pix_ce = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1; in_data = d; in_sof = sof_first && (i == 0);
      got = 0;
      for (int t = 0; t < 40 && !got; t++) begin
        step();
        got = last_acc;
      end
      if (!got) begin
        n_total++;
        $display("FAIL push_timeout: pixel %0d not accepted, got none expected accept", i);
        break;
      end
    end
    in_valid = 0; in_sof = 0;
  endtask

  task automatic do_reset();
    pix_ce = 0; in_valid = 0; in_sof = 0; active = 0;
    rst_n = 0;
    #1;
    chk("async_rgb", rgb, 12'h000);
    chk("async_uf", 12'(underflow), 12'h000);
    chk("async_ready", 12'(in_ready), 12'h000);
    model_reset();
    m_acc = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  initial begin
    #5;
    // Reset state.
    do_reset();
    chk("rst_in_ready", 12'(in_ready), 12'h001);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_uf", 12'(underflow), 12'h000);

    // Two lines with no reads fill both banks.
    in_valid = 1; in_data = 12'hF00;
    for (int i = 0; i < 330; i++) step();
    in_valid = 0;
    chk("fill2_ready", 12'(in_ready), 12'h000);
    chk("fill2_count", 12'(m_acc), 12'd320);

    // Partial line discarded by reset, then a clean green line.
    do_reset();
    push(50, 12'hAAA, 0);
    do_reset();
    push(160, 12'h0F0, 0);
    step();
    chk("line1_ready", 12'(in_ready), 12'h001);

    // Rows 24..26 show the line; no second line -> underflow and repeat.
    sweep_row(24, 0);
    chk("r24_c80", cap[80], 12'h0F0);
    chk("r24_c559", cap[559], 12'h0F0);
    chk("r24_c79", cap[79], BORDER);
    chk("r24_c0", cap[0], BORDER);
    chk("r24_c560", cap[560], BORDER);
    chk("r24_blank", cap[650], 12'h000);
    sweep_row(25, 0);
    sweep_row(26, 0);
`ifdef SCALER_SCANLINE_EN
    chk("r26_c200", cap[200], 12'h070);
`else
    chk("r26_c200", cap[200], 12'h0F0);
`endif
    chk("r26_uf", 12'(underflow), 12'h001);
    sweep_row(27, 0);
    chk("r27_c300", cap[300], 12'h0F0);
    sweep_row(28, 0);
    sweep_row(29, 0);
    chk("r28_29_uf", 12'(underflow), 12'h001);

    // Mid-line in_sof restarts at index 0; line completes 159 pixels later.
    do_reset();
    push(160, 12'hFFF, 0);
    push(57, 12'h3C5, 0);
    push(1, 12'hABC, 1);
    push(158, 12'h555, 0);
    step();
    chk("sof_not_done", 12'(in_ready), 12'h001);
    push(1, 12'h555, 0);
    step();
    chk("sof_done", 12'(in_ready), 12'h000);
    sweep_row(24, 0);
    chk("w_r24", cap[100], 12'hFFF);
    sweep_row(25, 0);
    chk("w_r25", cap[100], 12'hFFF);
    sweep_row(26, 0);
`ifdef SCALER_SCANLINE_EN
    chk("w_r26", cap[100], 12'h777);
`else
    chk("w_r26", cap[100], 12'hFFF);
`endif
    chk("w_uf", 12'(underflow), 12'h000);
    sweep_row(27, 0);
    chk("sof_idx0", cap[80], 12'hABC);
    chk("sof_idx0b", cap[82], 12'hABC);
    chk("sof_idx1", cap[83], 12'h555);
    chk("sof_idx159", cap[559], 12'h555);

    // Randomized traffic against the model.
    do_reset();
    wmode = 1;
    for (int v = 24; v < 36; v++) sweep_row(v, 1);
    sweep_row(Y_END, 1);
    wmode = 0;

    // Rows past the window free nothing.
    do_reset();
    push(320, 12'h0AB, 0);
    step();
    sweep_row(Y_END, 0);
    chk("below_ready", 12'(in_ready), 12'h000);
    chk("below_uf", 12'(underflow), 12'h000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
